dtree_feature_loader: RTL

//  Sequential front end for the combinational decision-tree classifier.
//  - Assembles a serial byte stream of quantised features into a parallel register bank.
//  - Drives the bank to the tree, waits a fixed settle time and captures the class.
//  - Returns the class over a valid/ready handshake.
//  - Sits between the sensor/ADC byte interface and the tree.

---
 rtl/dtree_pkg.sv | 18 +
 rtl/dtree_feature_loader_if.sv | 27 ++
 rtl/dtree_class_counter.sv | 44 ++++
 rtl/dtree_feature_loader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// rtl/dtree_pkg.sv - shared types and constants for the decision-tree feature loader
// Contents: loader FSM state enum, default feature/class widths, class_t, counter width.
package dtree_pkg;

  localparam int DEF_FEAT_W  = 8;
  localparam int DEF_CLASS_W = 2;
  localparam int CNT_W       = 16;

  typedef logic [DEF_CLASS_W-1:0] class_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EVAL  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/dtree_feature_loader_if.sv
// rtl/dtree_feature_loader_if.sv - feature byte stream and class result handshake bundle
// Signals:
//   s_valid/s_ready/s_data/s_last : feature byte stream into the loader
//   m_valid/m_ready/m_class       : class result out of the loader
// Modports: slave = loader side, master = producer/consumer side.
interface dtree_feature_loader_if #(
  parameter int FEAT_W  = 8,
  parameter int CLASS_W = 2
);
  logic               s_valid;
  logic               s_ready;
  logic [FEAT_W-1:0]  s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [CLASS_W-1:0] m_class;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class
  );
endinterface

// File: rtl/dtree_class_counter.sv
// rtl/dtree_class_counter.sv - bank of saturating per-class result counters
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all counters)
//   inc        : one result handed off this cycle
//   cls        : class of that result
//   class_cnt  : counter c at bits [CNT_W*c +: CNT_W], holds at all-ones
module dtree_class_counter
  import dtree_pkg::*;
#(
  parameter int CLASS_W = DEF_CLASS_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             inc,
  input  logic [CLASS_W-1:0]               cls,
  output logic [(2**CLASS_W)*CNT_W-1:0]    class_cnt
);
  localparam int NUM_CLASSES = 2**CLASS_W;

  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];

  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      cnt_d[c] = cnt_q[c];
      if (inc && (cls == CLASS_W'(c)) && (cnt_q[c] != {CNT_W{1'b1}})) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_out
    assign class_cnt[CNT_W*g +: CNT_W] = cnt_q[g];
  end

endmodule

// File: rtl/dtree_feature_loader.sv
// rtl/dtree_feature_loader.sv - serial feature loader and result capture for a combinational decision tree
// Optional feature macro: DTREE_CLASS_CNT_EN (adds class_cnt and the per-class counter bank).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : slave side of the feature stream / class result handshake
//   tree_vec    : feature bank, feature i at [FEAT_W*i +: FEAT_W]
//   tree_class  : combinational class from the tree
//   frame_err   : sticky frame-length error, cleared only by reset
//   class_cnt   : per-class 16-bit saturating result counters (DTREE_CLASS_CNT_EN only)
module dtree_feature_loader
  import dtree_pkg::*;
#(
  parameter int NUM_FEATURES = 20,
  parameter int FEAT_W       = DEF_FEAT_W,
  parameter int CLASS_W      = DEF_CLASS_W,
  parameter int EVAL_LAT     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  dtree_feature_loader_if.slave          bus,
  output logic [NUM_FEATURES*FEAT_W-1:0] tree_vec,
  input  logic [CLASS_W-1:0]             tree_class,
  output logic                           frame_err
`ifdef DTREE_CLASS_CNT_EN
  ,
  output logic [(2**CLASS_W)*CNT_W-1:0]  class_cnt
`endif
);
  localparam int              IDX_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
  localparam logic [3:0]       LAT      = 4'(EVAL_LAT);

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [3:0]                      cnt_q, cnt_d;
  logic [NUM_FEATURES*FEAT_W-1:0]  vec_q, vec_d;
  logic                            m_valid_q, m_valid_d;
  logic [CLASS_W-1:0]              m_class_q, m_class_d;
  logic                            err_q, err_d;

  logic s_ready_c;
  logic s_fire;
  logic m_fire;
  logic at_last;

  // Ready depends only on state, so there is no combinational path from m_ready to s_ready.
  assign s_ready_c = (state_q == LOAD) || (state_q == DRAIN);
  assign s_fire    = bus.s_valid & s_ready_c;
  assign m_fire    = m_valid_q & bus.m_ready;
  assign at_last   = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      cnt_q     <= '0;
      vec_q     <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (s_fire && at_last) state_d = bus.s_last ? EVAL : DRAIN;
      end
      EVAL: begin
        if (cnt_q == 4'd0) state_d = HOLD;
      end
      HOLD: begin
        if (m_fire) state_d = LOAD;
      end
      DRAIN: begin
        if (s_fire && bus.s_last) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    err_d     = err_q;
    case (state_q)
      LOAD: begin
        if (s_fire) begin
          // Every accepted LOAD byte lands in the bank, including those of bad frames.
          vec_d[FEAT_W*idx_q +: FEAT_W] = bus.s_data;
          if (bus.s_last) begin
            idx_d = '0;
            if (at_last) cnt_d = LAT;
            else         err_d = 1'b1;
          end else if (at_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EVAL: begin
        if (cnt_q == 4'd0) begin
          m_class_d = tree_class;
          m_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (m_fire) m_valid_d = 1'b0;
      end
      DRAIN: begin
        if (s_fire && bus.s_last) idx_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_class = m_class_q;
  assign tree_vec    = vec_q;
  assign frame_err   = err_q;

`ifdef DTREE_CLASS_CNT_EN
  dtree_class_counter #(
    .CLASS_W (CLASS_W)
  ) u_class_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (m_fire),
    .cls       (m_class_q),
    .class_cnt (class_cnt)
  );
`endif

endmodule
